seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential unsigned restoring divider for the ALU, producing one quotient bit per clock.
- Each trial subtraction is done by one ADDER_LL_CLA instance, configured as A + ~B + 1.
- It is the subtract/inverse counterpart to the combinational CLA adder path.
- It runs multi-cycle under a Start/Busy/Done handshake and sits beside the adder in the ALU datapath.

Parameters:
- BITS, 8, operand/quotient/remainder width. Legal values are 4, 8, 16, 32, 64. Other values are rejected at elaboration with $error.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST_N  input  1  synchronous active-low reset, sampled on rising edge of CLK.
- Start  input  1  request; sampled only in IDLE or DONE state.
- A  input  BITS  dividend; captured when Start is accepted.
- B  input  BITS  divisor; captured when Start is accepted.
- Busy  output  1  high while division is iterating.
- Done  output  1  single-cycle pulse; Q/R/DivZero valid from this cycle.
- Q  output  BITS  quotient.
- R  output  BITS  remainder.
- DivZero  output  1  divisor was zero; valid with Done.

Behaviour:
- Reset, when RST_N=0 at an edge:
  - State goes to IDLE.
  - Busy=0, Done=0, DivZero=0, Q=0, R=0; internal counter and registers cleared.
  - Reset mid-operation aborts with no Done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start=1 with B!=0: capture A into the quotient shift register and B into the divisor register, clear the partial remainder, load count=BITS, go to RUN.
  - Start=1 with B==0: go to DONE with Q=all ones, R=A, DivZero=1.
- RUN, one iteration per cycle:
  - Shifted = {partial_rem[BITS-2:0], qreg[BITS-1]}; ShiftOut = partial_rem[BITS-1].
  - Trial = Shifted - divisor, computed by ADDER_LL_CLA #(BITS) with B input = ~divisor and Cin=1.
  - Success = ShiftOut | Cout.
  - On success, partial_rem <= Trial[BITS-1:0]; otherwise partial_rem <= Shifted.
  - qreg <= {qreg[BITS-2:0], Success}.
  - count decrements; when count reaches 1, the iteration completes, then go to DONE.
  - The Over output of the adder is unused.
- DONE:
  - Done=1 for exactly one cycle; Q=qreg, R=partial_rem, DivZero as computed.
  - Next cycle: if Start=1, accept it exactly as in IDLE (back-to-back allowed); otherwise go to IDLE.
- Outputs Q/R/DivZero hold their values in IDLE until the next accepted Start. DivZero clears on acceptance of a non-zero-divisor Start.
- Latency, with Start accepted at edge k:
  - Busy=1 in cycles k+1 .. k+BITS.
  - Done=1 in cycle k+BITS+1.
  - Divide-by-zero: Done=1 in cycle k+1 and Busy never asserts.
- Start while in RUN is ignored; A and B changes during RUN have no effect.
- Invariants:
  - Busy and Done are never high simultaneously.
  - When DivZero=0: A == Q*B + R and R < B.
- Arithmetic is purely unsigned; no overflow case exists except divide-by-zero.

Test Plan:
- BITS=8, A=100, B=7, Start pulse at edge k -> Busy cycles k+1..k+8; Done at k+9 with Q=14, R=2, DivZero=0.
- A=5, B=9 -> Q=0, R=5. A=255, B=1 -> Q=255, R=0. A=255, B=128 -> Q=1, R=127 (exercises the ShiftOut path).
- A=200, B=0 -> Done one cycle after Start, DivZero=1, Q=255, R=200, Busy stays 0. A following 200/3 run clears DivZero and gives Q=66, R=2.
- Start held high continuously with 100/7 then 50/5 -> Done pulses 9 cycles apart with results 14/2 then 10/0. A Start pulse mid-RUN with A=1, B=1 is ignored and the in-flight result is unchanged.
- RST_N=0 for one edge at RUN cycle 4 -> next cycle Busy=0, Done=0, Q=0, R=0, and no Done pulse follows. A fresh 100/7 then completes normally.
- Random regression with BITS=4, 8, 16, 32 and 10k random operand pairs (including B=0) -> Q/R match the reference A/B and A%B model. For B=0 -> Q=all ones, R=A.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Trial subtraction is Shifted + ~divisor + 1 through a Kogge-Stone style CLA.
module ADDER_LL_CLA #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    input  logic            Cin,
    output logic [BITS-1:0] S,
    output logic            Cout,
    output logic            Over
);
    logic [BITS-1:0] g_q, p_q;
    logic [BITS:0]   c;
    // Parallel-prefix group generate/propagate, doubling the span each level
    always_comb begin
        g_q = A & B;
        p_q = A ^ B;
        for (int s = 1; s < BITS; s = s * 2) begin
            g_q = g_q | (p_q & (g_q << s));
            p_q = p_q & ((p_q << s) | ((BITS'(1) << s) - BITS'(1)));
        end
    end
    assign c    = {g_q | (p_q & {BITS{Cin}}), Cin};
    assign S    = A ^ B ^ c[BITS-1:0];
    assign Cout = c[BITS];
    assign Over = c[BITS] ^ c[BITS-1];
endmodule

module seq_divider #(
    parameter int BITS = 8
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            Start,
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    output logic            Busy,
    output logic            Done,
    output logic [BITS-1:0] Q,
    output logic [BITS-1:0] R,
    output logic            DivZero
);
    localparam int CW = $clog2(BITS) + 1;

    if (!(BITS == 4 || BITS == 8 || BITS == 16 || BITS == 32 || BITS == 64)) begin : g_bad_bits
        $error("seq_divider: BITS must be 4, 8, 16, 32 or 64");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] qreg_q, qreg_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dz_q, dz_d;
    logic [BITS-1:0] shifted, trial;
    logic            cout, success, accept, b_zero, over_unused;

    assign shifted = {rem_q[BITS-2:0], qreg_q[BITS-1]};
    assign success = rem_q[BITS-1] | cout;
    assign accept  = Start && state_q != RUN;
    assign b_zero  = B == '0;

    ADDER_LL_CLA #(.BITS(BITS)) u_sub (
        .A    (shifted),
        .B    (~dvs_q),
        .Cin  (1'b1),
        .S    (trial),
        .Cout (cout),
        .Over (over_unused)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            qreg_q  <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            qreg_q  <= qreg_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = accept ? (b_zero ? DONE : RUN) :
                  state_q == RUN ? (cnt_q == CW'(1) ? DONE : RUN) : IDLE;
    end

    // Divide-by-zero reuses the quotient/remainder registers for its fixed result
    always_comb begin
        qreg_d = accept ? (b_zero ? '1 : A) :
                 state_q == RUN ? {qreg_q[BITS-2:0], success} : qreg_q;
        rem_d  = accept ? (b_zero ? A : '0) :
                 state_q == RUN ? (success ? trial : shifted) : rem_q;
        dvs_d  = accept && !b_zero ? B : dvs_q;
        cnt_d  = accept && !b_zero ? CW'(BITS) :
                 state_q == RUN ? cnt_q - CW'(1) : cnt_q;
        dz_d   = accept ? b_zero : dz_q;
    end

    always_comb begin
        Busy    = state_q == RUN;
        Done    = state_q == DONE;
        Q       = qreg_q;
        R       = rem_q;
        DivZero = dz_q;
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider (BITS=8) with a result scoreboard.
module tb_seq_divider;
    logic       CLK = 1'b0, RST_N = 1'b0, Start = 1'b0;
    logic [7:0] A = '0, B = '0, Q, R;
    logic       Busy, Done, DivZero;
    int         vectors = 0, miscompares = 0;
    logic [16:0] sb_q[$];

    seq_divider #(.BITS(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .Start(Start), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .Q(Q), .R(R), .DivZero(DivZero)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        assert (!(Busy && Done)) else begin
            miscompares++;
            $error("FAIL busy_done_overlap: Busy=%0b Done=%0b", Busy, Done);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
        return b == 0 ? {1'b1, 8'hFF, a} : {1'b0, 8'(a / b), 8'(a % b)};
    endfunction

    task automatic pop_check(input string tag);
        logic [16:0] e;
        check({tag, "_done"}, {31'd0, Done}, 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_q"}, {24'd0, Q}, {24'd0, e[15:8]});
            check({tag, "_r"}, {24'd0, R}, {24'd0, e[7:0]});
            check({tag, "_dz"}, {31'd0, DivZero}, {31'd0, e[16]});
        end
    endtask

    task automatic do_div(input logic [7:0] a, input logic [7:0] b, input bit mid_start);
        int n, nb;
        @(negedge CLK);
        A = a; B = b; Start = 1'b1;
        sb_q.push_back(model(a, b));
        @(negedge CLK);
        Start = 1'b0;
        n = 1; nb = 0;
        while (!Done && n < 40) begin
            if (Busy) nb++;
            if (mid_start && n == 4) begin A = 8'd1; B = 8'd1; Start = 1'b1; end
            else if (mid_start && n == 5) Start = 1'b0;
            @(negedge CLK);
            n++;
        end
        check("latency", n, b == 0 ? 1 : 9);
        check("busy_cycles", nb, b == 0 ? 0 : 8);
        pop_check("div");
    endtask

    initial begin
        int n, first, a, b;
        repeat (3) @(negedge CLK);
        check("rst_busy", {31'd0, Busy}, 0);
        check("rst_done", {31'd0, Done}, 0);
        check("rst_q", {24'd0, Q}, 0);
        check("rst_r", {24'd0, R}, 0);
        check("rst_dz", {31'd0, DivZero}, 0);
        RST_N = 1'b1;

        do_div(8'd100, 8'd7, 1'b0);
        do_div(8'd5, 8'd9, 1'b0);
        do_div(8'd255, 8'd1, 1'b0);
        do_div(8'd255, 8'd128, 1'b0);
        do_div(8'd200, 8'd0, 1'b0);
        repeat (2) @(negedge CLK);
        check("hold_dz", {31'd0, DivZero}, 1);
        check("hold_q", {24'd0, Q}, 255);
        check("hold_r", {24'd0, R}, 200);
        do_div(8'd200, 8'd3, 1'b0);
        do_div(8'd100, 8'd7, 1'b1);

        // Start held high: second operation accepted in the DONE cycle of the first
        @(negedge CLK);
        A = 8'd100; B = 8'd7; Start = 1'b1;
        sb_q.push_back(model(8'd100, 8'd7));
        sb_q.push_back(model(8'd50, 8'd5));
        @(negedge CLK);
        A = 8'd50; B = 8'd5;
        first = -1;
        for (n = 1; n < 40; n++) begin
            if (first >= 0 && n == first + 1) Start = 1'b0;
            if (Done) begin
                pop_check("b2b");
                if (first >= 0) break;
                first = n;
            end
            @(negedge CLK);
        end
        check("b2b_first", first, 9);
        check("b2b_gap", n - first, 9);
        Start = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset during RUN aborts without a Done pulse
        A = 8'd100; B = 8'd7; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (3) @(negedge CLK);
        check("pre_rst_busy", {31'd0, Busy}, 1);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        check("abort_busy", {31'd0, Busy}, 0);
        check("abort_done", {31'd0, Done}, 0);
        check("abort_q", {24'd0, Q}, 0);
        check("abort_r", {24'd0, R}, 0);
        first = 0;
        repeat (12) begin
            @(negedge CLK);
            if (Done) first++;
        end
        check("abort_no_done", first, 0);
        do_div(8'd100, 8'd7, 1'b0);

        for (int i = 0; i < 300; i++) begin
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
            do_div(8'(a), 8'(b), 1'b0);
        end
        check("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
